// File: rtl/input_debounce_pair.sv
// input_debounce_pair: two-channel synchroniser + counter debouncer with level, edge pulses and a both-stable flag
module input_debounce_pair #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic stable
);
  typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  logic [1:0] raw, x_in, clean, rise, fall, stab;
  logic stable_d, stable_q;
  assign raw = {b_raw, a_raw};
  assign x_in = ACTIVE_LOW ? ~raw : raw;
  for (genvar i = 0; i < 2; i++) begin : g_ch
    state_e state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic s1_d, s1_q, s2_d, s2_q, clean_d, clean_q, rise_d, rise_q, fall_d, fall_q;
    always_comb begin
      s1_d = x_in[i];
      s2_d = s1_q;
      state_d = state_q;
      cnt_d = cnt_q;
      clean_d = clean_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      case (state_q)
        STABLE_LO: if (s2_q) begin
          state_d = CHECK_HI;
          cnt_d = CNT_W'(1);
        end
        CHECK_HI: if (!s2_q) begin
          state_d = STABLE_LO;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_HI;
          clean_d = 1'b1;
          rise_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
        STABLE_HI: if (!s2_q) begin
          state_d = CHECK_LO;
          cnt_d = CNT_W'(1);
        end
        CHECK_LO: if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_LO;
          clean_d = 1'b0;
          fall_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = STABLE_LO;
      endcase
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        state_q <= STABLE_LO;
        cnt_q <= '0;
        clean_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        state_q <= state_d;
        cnt_q <= cnt_d;
        clean_q <= clean_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
    assign stab[i] = (state_d == STABLE_LO) || (state_d == STABLE_HI);
    assign clean[i] = clean_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end
  // stable is registered from next-state so it lines up with the FSM state it describes
  assign stable_d = &stab;
  always_ff @(posedge clk) begin
    if (rst) stable_q <= 1'b1;
    else stable_q <= stable_d;
  end
  assign a_clean = clean[0];
  assign b_clean = clean[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];
  assign stable = stable_q;
endmodule

// File: tb/tb_input_debounce_pair.sv
// tb_input_debounce_pair: directed stimulus, window-based reference model and literal spot checks
module tb_input_debounce_pair;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic a_raw = 1'b0, b_raw = 1'b0, a2_raw = 1'b1, b2_raw = 1'b1;
  logic a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, stable;
  logic a2_clean, b2_clean, a2_rise, a2_fall, b2_rise, b2_fall, stable2;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  input_debounce_pair #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean), .b_clean(b_clean), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .stable(stable));
  input_debounce_pair #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .a_raw(a2_raw), .b_raw(b2_raw),
    .a_clean(a2_clean), .b_clean(b2_clean), .a_rise(a2_rise), .a_fall(a2_fall),
    .b_rise(b2_rise), .b_fall(b2_fall), .stable(stable2));
  wire [6:0] outs = {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, stable};
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // Model: a channel takes level v once its last D synchronised samples all equal v
  bit hist[2][$];
  bit s1m[2], s2m[2], cm[2], rm[2], fm[2];
  bit stm, mvalid = 1'b0;
  always @(posedge clk) begin
    bit xin[2];
    bit v, ok;
    xin[0] = a_raw;
    xin[1] = b_raw;
    if (rst) begin
      mvalid = 1'b1;
      stm = 1'b1;
      for (int c = 0; c < 2; c++) begin
        hist[c].delete();
        s1m[c] = 1'b0; s2m[c] = 1'b0; cm[c] = 1'b0; rm[c] = 1'b0; fm[c] = 1'b0;
      end
    end else begin
      stm = 1'b1;
      for (int c = 0; c < 2; c++) begin
        hist[c].push_back(s2m[c]);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        rm[c] = 1'b0;
        fm[c] = 1'b0;
        if (hist[c].size() == D) begin
          v = hist[c][0];
          ok = 1'b1;
          for (int j = 1; j < D; j++) if (hist[c][j] != v) ok = 1'b0;
          if (ok && v != cm[c]) begin
            cm[c] = v;
            rm[c] = v;
            fm[c] = !v;
          end
        end
        if (hist[c][hist[c].size()-1] != cm[c]) stm = 1'b0;
        s2m[c] = s1m[c];
        s1m[c] = xin[c];
      end
    end
  end
  always @(negedge clk)
    if (mvalid) chk("cycle", {1'b0, outs}, {1'b0, cm[0], cm[1], rm[0], fm[0], rm[1], fm[1], stm});
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {1'b0, outs}, 8'h01);
    chk("reset_state_al", {1'b0, a2_clean, b2_clean, a2_rise, a2_fall, b2_rise, b2_fall, stable2}, 8'h01);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    // 1: single clean press
    a_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("t1_stable_k1", {7'b0, stable}, 8'h1);
    @(posedge clk);
    #1 chk("t1_stable_k2", {7'b0, stable}, 8'h0);
    repeat (2) @(posedge clk);
    #1 chk("t1_k4", {5'b0, a_clean, a_rise, stable}, 8'h0);
    @(posedge clk);
    #1 chk("t1_k5", {5'b0, a_clean, a_rise, stable}, 8'h7);
    @(posedge clk);
    #1 chk("t1_k6_pulse_end", {6'b0, a_clean, a_rise}, 8'h2);
    @(negedge clk) a_raw = 1'b0;
    repeat (10) @(negedge clk);
    // 2: short glitch on b
    b_raw = 1'b1;
    repeat (3) @(negedge clk);
    b_raw = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_b_glitch", {5'b0, b_clean, b_rise, stable}, 8'h1);
    // 3: bouncing a, then held
    a_raw = 1'b1; @(negedge clk);
    a_raw = 1'b0; @(negedge clk);
    a_raw = 1'b1; @(negedge clk);
    a_raw = 1'b0; @(negedge clk);
    a_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t3_k4", {6'b0, a_clean, a_rise}, 8'h0);
    @(posedge clk);
    #1 chk("t3_k5", {6'b0, a_clean, a_rise}, 8'h3);
    @(negedge clk) a_raw = 1'b0;
    repeat (10) @(negedge clk);
    // 4: both channels together
    a_raw = 1'b1; b_raw = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("t4_rise_pair", {4'b0, a_rise, b_rise, a_fall, b_fall}, 8'hC);
    @(negedge clk) begin a_raw = 1'b0; b_raw = 1'b0; end
    repeat (6) @(posedge clk);
    #1 chk("t4_fall_pair", {4'b0, a_rise, b_rise, a_fall, b_fall}, 8'h3);
    repeat (5) @(negedge clk);
    // 5: reset mid-qualification
    a_raw = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("t5_reset", {1'b0, outs}, 8'h01);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("t5_j4", {6'b0, a_clean, a_rise}, 8'h0);
    @(posedge clk);
    #1 chk("t5_j5", {6'b0, a_clean, a_rise}, 8'h3);
    @(negedge clk) a_raw = 1'b0;
    repeat (10) @(negedge clk);
    // 6: active-low instance
    chk("t6_idle", {6'b0, a2_clean, b2_clean}, 8'h0);
    a2_raw = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("t6_k4", {6'b0, a2_clean, a2_rise}, 8'h0);
    @(posedge clk);
    #1 chk("t6_k5", {6'b0, a2_clean, a2_rise}, 8'h3);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
